// File: rtl/counter_gen.sv
// counter_gen: prescaled up/down/up-down timer with shadowed period/prescale; define COUNTER_GEN_COMPARE_EN for compare output
module counter_gen #(
    parameter int CNT_W = 16,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             count_reset,
    input  logic [1:0]       mode,
    input  logic             one_shot,
    input  logic [CNT_W-1:0] period,
    input  logic [PSC_W-1:0] prescale,
`ifdef COUNTER_GEN_COMPARE_EN
    input  logic [CNT_W-1:0] cmp,
    output logic             cmp_match,
`endif
    output logic [CNT_W-1:0] count_val,
    output logic             dir,
    output logic             ovf,
    output logic             unf,
    output logic             halted
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d;
    logic [PSC_W-1:0] psc_q, psc_d, pre_q, pre_d;
    logic             dir_q, dir_d, ovf_q, ovf_d, unf_q, unf_d, halted_q, halted_d;
    logic             tick, upd, ld;
    assign tick = en && !halted_q && (psc_q == pre_q);
    // Shadows are transparent while cleared or disabled, otherwise they follow the update event
    assign ld    = count_reset || !en || upd;
    assign per_d = ld ? period : per_q;
    assign pre_d = ld ? prescale : pre_q;
    // Next-state: count_reset beats disable beats halt beats the prescaled tick
    always_comb begin
        cnt_d    = cnt_q;
        psc_d    = psc_q;
        dir_d    = dir_q;
        halted_d = halted_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        upd      = 1'b0;
        if (count_reset) begin
            cnt_d    = '0;
            psc_d    = '0;
            dir_d    = (mode != 2'b01);
            halted_d = 1'b0;
        end else if (!en) begin
            psc_d    = '0;
            halted_d = 1'b0;
        end else if (!halted_q && !tick) begin
            psc_d = psc_q + 1'b1;
        end else if (tick) begin
            psc_d = '0;
            if (mode == 2'b01) begin
                dir_d = 1'b0;
                upd   = (cnt_q == '0);
                unf_d = upd;
                cnt_d = upd ? per_q : cnt_q - ONE;
            end else if (mode == 2'b10) begin
                if (dir_q && cnt_q >= per_q) begin
                    cnt_d = (per_q == '0) ? '0 : per_q - ONE;
                    dir_d = 1'b0;
                    ovf_d = 1'b1;
                end else if (!dir_q && cnt_q == '0) begin
                    cnt_d = (per_q == '0) ? '0 : ONE;
                    dir_d = 1'b1;
                    unf_d = 1'b1;
                    upd   = 1'b1;
                end else begin
                    cnt_d = dir_q ? cnt_q + ONE : cnt_q - ONE;
                end
            end else begin
                dir_d = 1'b1;
                upd   = (cnt_q >= per_q);
                ovf_d = upd;
                cnt_d = upd ? '0 : cnt_q + ONE;
            end
            halted_d = upd && one_shot;
        end
    end
    // State registers, including the registered event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            psc_q    <= '0;
            dir_q    <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            halted_q <= 1'b0;
            per_q    <= '0;
            pre_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            psc_q    <= psc_d;
            dir_q    <= dir_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            halted_q <= halted_d;
            per_q    <= per_d;
            pre_q    <= pre_d;
        end
    end
    assign count_val = cnt_q;
    assign dir       = dir_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign halted    = halted_q;
`ifdef COUNTER_GEN_COMPARE_EN
    logic [CNT_W-1:0] cmp_act_q, cmp_act_d;
    logic             cmp_match_q, cmp_match_d;
    assign cmp_act_d   = ld ? cmp : cmp_act_q;
    assign cmp_match_d = (count_reset || tick) && (cnt_d == cmp_act_d) && (cnt_q != cmp_act_q);
    // Compare shadow and edge-only match pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_act_q   <= '0;
            cmp_match_q <= 1'b0;
        end else begin
            cmp_act_q   <= cmp_act_d;
            cmp_match_q <= cmp_match_d;
        end
    end
    assign cmp_match = cmp_match_q;
`endif
endmodule

// File: tb/tb_counter_gen.sv
// tb_counter_gen: directed checks of counter_gen modes, shadowing, one-shot and resets
module tb_counter_gen;
    logic       clk = 1'b0;
    logic       rst_n, en, count_reset, one_shot;
    logic [1:0] mode;
    logic [7:0] period;
    logic [3:0] prescale;
    logic [7:0] count_val;
    logic       dir, ovf, unf, halted;
    int n_cmp = 0;
    int n_err = 0;
    int ud_cnt [7] = '{1, 2, 3, 2, 1, 0, 1};
    int ud_dir [7] = '{1, 1, 1, 0, 0, 0, 1};
    int ud_ovf [7] = '{0, 0, 0, 1, 0, 0, 0};
    int ud_unf [7] = '{0, 0, 0, 0, 0, 0, 1};

    counter_gen #(.CNT_W(8), .PSC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .count_reset(count_reset),
        .mode(mode), .one_shot(one_shot), .period(period), .prescale(prescale),
        .count_val(count_val), .dir(dir), .ovf(ovf), .unf(unf), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int c, input int d, input int o, input int u, input int h);
        chk({tag, ".count"}, 32'(count_val), c);
        chk({tag, ".dir"}, 32'(dir), d);
        chk({tag, ".ovf"}, 32'(ovf), o);
        chk({tag, ".unf"}, 32'(unf), u);
        chk({tag, ".halted"}, 32'(halted), h);
    endtask

    task automatic restart(input logic [1:0] m, input logic [7:0] p, input logic [3:0] s, input logic os);
        mode = m;
        period = p;
        prescale = s;
        one_shot = os;
        en = 1'b1;
        count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        en = 1'b0;
        count_reset = 1'b0;
        one_shot = 1'b0;
        mode = 2'b00;
        period = 8'd0;
        prescale = 4'd0;
        #1 rst_n = 1'b0;
        #1 chk_st("reset", 0, 1, 0, 0, 0);
        step(2);
        rst_n = 1'b1;
        // up mode, prescale 2: advance every 3 cycles
        restart(2'b00, 8'd4, 4'd2, 1'b0);
        chk_st("up.clr", 0, 1, 0, 0, 0);
        step(2);
        chk("up.psc_hold", 32'(count_val), 0);
        step(1);
        chk("up.first", 32'(count_val), 1);
        step(9);
        chk_st("up.top", 4, 1, 0, 0, 0);
        step(2);
        chk_st("up.top_hold", 4, 1, 0, 0, 0);
        step(1);
        chk_st("up.wrap", 0, 1, 1, 0, 0);
        step(1);
        chk_st("up.after", 0, 1, 0, 0, 0);
        // down mode
        restart(2'b01, 8'd3, 4'd0, 1'b0);
        chk_st("dn.clr", 0, 0, 0, 0, 0);
        step(1);
        chk_st("dn.load", 3, 0, 0, 1, 0);
        step(1);
        chk_st("dn.2", 2, 0, 0, 0, 0);
        step(2);
        chk_st("dn.0", 0, 0, 0, 0, 0);
        step(1);
        chk_st("dn.reload", 3, 0, 0, 1, 0);
        // up-down mode
        restart(2'b10, 8'd3, 4'd0, 1'b0);
        chk_st("ud.clr", 0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk_st($sformatf("ud.%0d", i), ud_cnt[i], ud_dir[i], ud_ovf[i], ud_unf[i], 0);
        end
        // period shadowing: new period only after the wrap
        restart(2'b00, 8'd9, 4'd0, 1'b0);
        step(2);
        chk("sh.at2", 32'(count_val), 2);
        period = 8'd5;
        step(4);
        chk("sh.past5", 32'(count_val), 6);
        step(3);
        chk_st("sh.at9", 9, 1, 0, 0, 0);
        step(1);
        chk_st("sh.wrap9", 0, 1, 1, 0, 0);
        step(5);
        chk_st("sh.at5", 5, 1, 0, 0, 0);
        step(1);
        chk_st("sh.wrap5", 0, 1, 1, 0, 0);
        // one-shot
        restart(2'b00, 8'd2, 4'd0, 1'b1);
        step(2);
        chk("os.at2", 32'(count_val), 2);
        step(1);
        chk_st("os.wrap", 0, 1, 1, 0, 1);
        step(2);
        chk_st("os.frozen", 0, 1, 0, 0, 1);
        en = 1'b0;
        step(1);
        chk_st("os.dis", 0, 1, 0, 0, 0);
        en = 1'b1;
        step(1);
        chk_st("os.resume1", 1, 1, 0, 0, 0);
        step(1);
        chk("os.resume2", 32'(count_val), 2);
        // asynchronous reset mid-count
        restart(2'b00, 8'd20, 4'd0, 1'b0);
        step(7);
        chk("ar.at7", 32'(count_val), 7);
        #2 rst_n = 1'b0;
        #1 chk_st("ar.async", 0, 1, 0, 0, 0);
        step(1);
        rst_n = 1'b1;
        // count_reset beats a wrapping tick
        restart(2'b00, 8'd3, 4'd0, 1'b0);
        step(3);
        chk("cr.at3", 32'(count_val), 3);
        count_reset = 1'b1;
        step(1);
        count_reset = 1'b0;
        chk_st("cr.clr", 0, 1, 0, 0, 0);
        step(1);
        chk_st("cr.next", 1, 1, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/counter_gen.md
Name: counter_gen

Overview:
- Parametrised successor of the peripheral timer counter: prescaled up, down and up-down (center-aligned) counting, with optional one-shot operation.
- Period and prescale are shadowed; new values take effect only at an update event, so a running PWM period never glitches.
- Registered overflow/underflow event pulses for the register block and PWM/interrupt logic.
- Sits between the peripheral register file and the PWM compare channels.

Parameters:
- CNT_W, 16, counter and period width in bits (min 2).
- PSC_W, 8, prescaler width in bits (min 1).

Ports:
- clk  input  1  peripheral clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable
- count_reset  input  1  synchronous clear of counter, prescaler and direction; reloads shadows
- mode  input  2  00 up, 01 down, 10 up-down, 11 treated as up
- one_shot  input  1  1 = halt after the first update event
- period  input  CNT_W  requested period (top value)
- prescale  input  PSC_W  requested prescale; tick every prescale+1 cycles
- count_val  output  CNT_W  current count
- dir  output  1  1 = counting up, 0 = counting down
- ovf  output  1  one-cycle pulse when the top is reached and the counter wraps or turns
- unf  output  1  one-cycle pulse when the counter wraps or turns at 0
- halted  output  1  one-shot completed; counter frozen

Behaviour:
- Reset (async, rst_n=0):
  - count_val=0, prescaler count=0, dir=1, ovf=0, unf=0, halted=0.
  - period_act=0, prescale_act=0.
- Priority per clk edge: count_reset > !en > halted > tick logic.
- count_reset:
  - count_val=0, prescaler count=0, dir=(mode==01 ? 0 : 1), halted=0.
  - period_act<=period, prescale_act<=prescale; ovf/unf=0.
- en=0:
  - count_val and dir hold; prescaler count=0.
  - Shadows load every cycle (transparent while disabled).
  - halted cleared.
- Tick:
  - Active when en=1, halted=0 and prescaler count==prescale_act.
  - Prescaler count then returns to 0; otherwise it increments by 1.
  - prescale_act=0 means a tick every cycle.
- Up mode (00/11), dir forced to 1:
  - count>=period_act: count<=0, ovf=1, update event.
  - Otherwise count+1.
- Down mode (01), dir forced to 0:
  - count==0: count<=period_act, unf=1, update event.
  - Otherwise count-1.
- Up-down mode (10):
  - dir=1 and count>=period_act: count<=period_act-1 (0 if period_act==0), dir<=0, ovf=1.
  - dir=0 and count==0: count<=1 (0 if period_act==0), dir<=1, unf=1, update event.
  - Otherwise count moves by ±1 per dir.
  - Sequence for P=3: 0,1,2,3,2,1,0,1...
- Update event: period_act<=period and prescale_act<=prescale in the same edge. The new values govern the next tick.
- ovf/unf are registered, high exactly one cycle, on the same edge the count wraps or turns.
- One-shot (one_shot=1 at the update event):
  - The wrap value is still loaded and the pulse still fires.
  - halted<=1; count, dir and prescaler freeze.
  - Cleared only by count_reset or en=0.
- Mode change while running: takes effect at the next tick; dir is re-forced on that tick for up/down modes.
- count>period_act after a period shrink:
  - up: wraps to 0 at the next tick (>= compare).
  - down: counts down normally.
- All arithmetic is CNT_W-bit modulo; the listed compares prevent any wrap through 2^CNT_W.

Optional Feature:
- Macro: COUNTER_GEN_COMPARE_EN.
- Defined:
  - Adds input cmp[CNT_W-1:0], shadowed alongside period (cmp_act).
  - Adds output cmp_match: one-cycle registered pulse on the edge where count_val becomes equal to cmp_act as a result of a tick or count_reset.
  - Holding an equal value does not re-pulse.
  - In up-down mode it fires on both the up and the down crossing.
- Undefined: no cmp port, no cmp_match port, no compare logic.

Test Plan:
- mode=00, prescale=2, period=4, en=1 -> count 0..4,0 advancing every 3 cycles; ovf high exactly 1 cycle with the 4->0 wrap.
- mode=01, prescale=0, period=3 -> 0,3,2,1,0,3; unf pulses with each 0->3 load; dir=0 throughout.
- mode=10, prescale=0, period=3 -> 0,1,2,3,2,1,0,1; ovf on 3->2 with dir->0; unf on 0->1 with dir->1.
- mode=00, period=9 running at count 2, write period=5 -> counter still reaches 9 and wraps; next cycle wraps at 5.
- one_shot=1, mode=00, period=2 -> 0,1,2,0 then halted=1 and count frozen at 0; en=0 for 1 cycle then en=1 resumes counting.
- rst_n=0 asserted mid-count at count=7 -> all outputs 0 (dir=1) immediately, without waiting for clk; count_reset with en=1 in the same cycle as a tick -> count=0 and no ovf.
